// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for serial_add_ctrl.
// The master side issues requests; the slave side is the sequencer.
// With SERIAL_SUB_EN defined, the bundle also carries the 'sub' select.
interface serial_add_ctrl_if #(
  parameter int unsigned N = 4
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: N-bit operands are fed LSB-first through a single
// full-adder cell, one bit per clock, with the carry held in a register.
// The result and final carry appear together with a one-cycle done pulse.
// Optional feature: define SERIAL_SUB_EN to add a 'sub' request bit that computes a - b
// (b inverted at latch time, carry-in forced to 1).

// Single combinational full-adder cell shared by every bit position.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_add_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_sh_q, b_sh_d;
  logic [N-1:0]    res_sh_q, res_sh_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic fa_sum;
  logic fa_cout;

  // Operand conditioning applied once, at the accepted start.
  logic [N-1:0] b_load;
  logic         carry_load;

`ifdef SERIAL_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored in that mode.
  always_comb begin
    b_load     = bus.sub ? ~bus.b : bus.b;
    carry_load = bus.sub ? 1'b1 : bus.cin;
  end
`else
  // Add-only build: operands pass straight through.
  always_comb begin
    b_load     = bus.b;
    carry_load = bus.cin;
  end
`endif

  fulladd u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state logic; everything holds unless a state below says otherwise.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end

      StRun: begin
        // Each sum bit enters at the MSB so bit 0 lands at the LSB after N shifts.
        res_sh_d = {fa_sum, res_sh_q[N-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == LastCnt) begin
          // Final bit: publish result; counter stays put so it never wraps.
          sum_d   = {fa_sum, res_sh_q[N-1:1]};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        // start is not sampled here; a held request is taken in the following IDLE cycle.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.busy = busy_q;
    bus.done = done_q;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl (N = 4).
// Define SERIAL_SUB_EN for both bench and RTL to include the subtract vectors.
module tb_serial_add_ctrl;

  localparam int unsigned N = 4;

  logic clk;
  logic rst;

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         scramble;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input logic sub, input logic start);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("note: sub vector in add-only build");
`endif
    bus.start = start;
  endtask

  // One request: pulse start, then follow busy/done and check result and timing.
  task automatic run_op(input vec_t v, input string tag);
    logic [N-1:0] prev_sum;
    logic         prev_cout;
    int           busy_cnt;
    int           lat;
    bit           got;
    bit           stable;
    @(negedge clk);
    drive_req(v.a, v.b, v.cin, v.sub, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    if (v.scramble) drive_req(~v.a, ~v.b, ~v.cin, 1'b0, 1'b0);
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    busy_cnt  = 0;
    lat       = -1;
    got       = 1'b0;
    stable    = 1'b1;
    for (int i = 0; i < 3 * N + 4 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        lat = i;
        check({tag, " busy_at_done"}, int'(bus.busy), 0);
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.sum !== prev_sum || bus.cout !== prev_cout) stable = 1'b0;
      end
    end
    check({tag, " done_seen"}, int'(got), 1);
    check({tag, " latency"}, lat, N);
    check({tag, " busy_cycles"}, busy_cnt, N);
    check({tag, " held_during_run"}, int'(stable), 1);
    check({tag, " sum"}, int'(bus.sum), int'(v.exp_sum));
    check({tag, " cout"}, int'(bus.cout), int'(v.exp_cout));
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(bus.done), 0);
    check({tag, " sum_held"}, int'(bus.sum), int'(v.exp_sum));
  endtask

  initial begin
    int first_done;
    int second_done;
    int n_done;
    bit idle_seen;
    bit spurious;
    vec_t v;

    // a, b, cin, sub, scramble, expected sum, expected cout
    vecs.push_back('{4'd5,  4'd3,  1'b0, 1'b0, 1'b0, 4'd8,  1'b0});
    vecs.push_back('{4'd15, 4'd1,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1});
    vecs.push_back('{4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0});
    vecs.push_back('{4'd9,  4'd6,  1'b1, 1'b0, 1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd10, 4'd5,  1'b0, 1'b0, 1'b0, 4'd15, 1'b0});
    vecs.push_back('{4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 4'd1,  1'b0});
    vecs.push_back('{4'd6,  4'd7,  1'b0, 1'b0, 1'b1, 4'd13, 1'b0});
`ifdef SERIAL_SUB_EN
    vecs.push_back('{4'd3,  4'd5,  1'b0, 1'b1, 1'b0, 4'd14, 1'b0});
    vecs.push_back('{4'd5,  4'd3,  1'b1, 1'b1, 1'b0, 4'd2,  1'b1});
    vecs.push_back('{4'd7,  4'd7,  1'b0, 1'b1, 1'b0, 4'd0,  1'b1});
    vecs.push_back('{4'd5,  4'd3,  1'b0, 1'b0, 1'b0, 4'd8,  1'b0});
`endif

    // Reset state.
    rst = 1'b1;
    drive_req('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset sum", int'(bus.sum), 0);
    check("reset cout", int'(bus.cout), 0);
    rst = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high: one op per 6 cycles, ignored in RUN and DONE.
    @(negedge clk);
    drive_req(4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    first_done  = -1;
    second_done = -1;
    n_done      = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    check("held first_done", first_done, N);
    check("held spacing", second_done - first_done, 6);
    check("held done_count", n_done, 2);
    check("held sum", int'(bus.sum), 4);
    bus.start = 1'b0;
    idle_seen = 1'b0;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) idle_seen = 1'b1;
    end
    check("held drains", int'(idle_seen), 1);

    // Reset during the second RUN cycle aborts the op and clears outputs.
    v = '{4'd9, 4'd4, 1'b0, 1'b0, 1'b0, 4'd13, 1'b0};
    run_op('{4'd11, 4'd3, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0}, "pre_rst");
    @(negedge clk);
    drive_req(v.a, v.b, v.cin, v.sub, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre-abort busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort sum", int'(bus.sum), 0);
    check("abort cout", int'(bus.cout), 0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 2 * N + 2; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) spurious = 1'b1;
    end
    check("abort no_done", int'(spurious), 0);
    run_op(v, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
